// File: rtl/lvds_pattern_gen_if.sv
// lvds_pattern_gen_if
// Coordinate-in / colour-out bundle between the LVDS serializer/timing block
// and the pattern generator. All signals live in the clk_3_5 pixel domain.
//   i_x, i_y      pixel-pair column / line published by the serializer
//   i_mode        pattern select (taken by the generator at frame start)
//   o_color       RGB for the odd pixel of the pair
//   o_color_even  RGB for the even pixel of the pair
//   o_frame_tick  one-cycle pulse at frame start
//   o_frame_cnt   completed-frame counter
// master: serializer side, slave: pattern generator side.
interface lvds_pattern_gen_if;
    logic [11:0] i_x;
    logic [11:0] i_y;
    logic [1:0]  i_mode;
    logic [23:0] o_color;
    logic [23:0] o_color_even;
    logic        o_frame_tick;
    logic [15:0] o_frame_cnt;

    modport master (
        output i_x, i_y, i_mode,
        input  o_color, o_color_even, o_frame_tick, o_frame_cnt
    );

    modport slave (
        input  i_x, i_y, i_mode,
        output o_color, o_color_even, o_frame_tick, o_frame_cnt
    );
endinterface

// File: rtl/lvds_pattern_gen.sv
// lvds_pattern_gen
// Test-pattern source for the dual-channel LVDS panel path. Takes the
// active-area pixel-pair coordinate and returns the odd/even RGB words one
// cycle later. Patterns: 0 grid + animated cursor, 1 colour bars,
// 2 x/y/frame gradient, 3 solid colour. Also produces a frame tick and a
// completed-frame counter.
// Ports:
//   i_clk     pixel clock (clk_3_5 domain)
//   i_resetn  asynchronous active-low reset
//   bus       lvds_pattern_gen_if.slave (coordinates, mode, colours, frame info)
module lvds_pattern_gen #(
    parameter int          H_ACTIVE    = 960,
    parameter int          V_ACTIVE    = 1200,
    parameter int          STEP_FRAMES = 4,
    parameter logic [23:0] SOLID_COLOR = 24'h0000FF
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    lvds_pattern_gen_if.slave  bus
);
    localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
    localparam int          SW     = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_FRAMES - 1);

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] RED   = 24'hFF0000;

    logic [11:0]   y_prev;
    logic [11:0]   cur_x, cur_y;
    logic [SW-1:0] step;
    logic [1:0]    mode_q;
    logic [15:0]   frame_cnt;
    logic          frame_tick;
    logic [23:0]   odd_q, even_q;
    logic [23:0]   odd_d, even_d;
    logic          frame_start;
    logic          in_range;
    logic [7:0]    x_inc;

    // y_prev resets to all-ones so the first y==0 after reset counts as a start.
    assign frame_start = (bus.i_y == 12'd0) && (y_prev != 12'd0);
    assign in_range    = (bus.i_x <= X_LAST) && (bus.i_y <= Y_LAST);
    assign x_inc       = bus.i_x[7:0] + 8'd1;

    function automatic logic [23:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    // Colour selection uses the registered frame state, so the frame-start
    // pixel still sees the previous frame's mode, cursor and count.
    always_comb begin
        odd_d  = 24'h000000;
        even_d = 24'h000000;
        if (in_range) begin
            case (mode_q)
                2'd0: begin
                    if (bus.i_x == 12'd0) begin
                        odd_d = WHITE; even_d = GREEN;
                    end else if (bus.i_x == cur_x) begin
                        odd_d = WHITE; even_d = WHITE;
                    end else if (bus.i_x == X_LAST) begin
                        odd_d = GREEN; even_d = WHITE;
                    end else if (bus.i_y == 12'd0 || bus.i_y == cur_y || bus.i_y == Y_LAST) begin
                        odd_d = RED;   even_d = RED;
                    end else begin
                        odd_d = GREEN; even_d = GREEN;
                    end
                end
                2'd1: begin
                    odd_d  = bar_color(bus.i_x[9:7]);
                    even_d = odd_d;
                end
                2'd2: begin
                    odd_d  = {bus.i_x[7:0], bus.i_y[7:0], frame_cnt[7:0]};
                    even_d = {x_inc,        bus.i_y[7:0], frame_cnt[7:0]};
                end
                default: begin
                    odd_d  = SOLID_COLOR;
                    even_d = SOLID_COLOR;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            y_prev     <= 12'hFFF;
            cur_x      <= 12'd0;
            cur_y      <= 12'd0;
            step       <= '0;
            mode_q     <= 2'd0;
            frame_cnt  <= 16'd0;
            frame_tick <= 1'b0;
        end else begin
            y_prev     <= bus.i_y;
            frame_tick <= frame_start;
            if (frame_start) begin
                frame_cnt <= frame_cnt + 16'd1;
                mode_q    <= bus.i_mode;
                // Cursor moves one step diagonally every STEP_FRAMES frames.
                if (step == STEP_LAST) begin
                    step  <= '0;
                    cur_x <= (cur_x == X_LAST) ? 12'd0 : cur_x + 12'd1;
                    cur_y <= (cur_y == Y_LAST) ? 12'd0 : cur_y + 12'd1;
                end else begin
                    step <= step + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            odd_q  <= 24'h000000;
            even_q <= 24'h000000;
        end else begin
            odd_q  <= odd_d;
            even_q <= even_d;
        end
    end

    assign bus.o_color      = odd_q;
    assign bus.o_color_even = even_q;
    assign bus.o_frame_tick = frame_tick;
    assign bus.o_frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_lvds_pattern_gen.sv
module tb_lvds_pattern_gen;
    localparam int H    = 960;
    localparam int V    = 1200;
    localparam int STEP = 4;
    localparam logic [23:0] SOLID = 24'h0000FF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lvds_pattern_gen_if bus();

    lvds_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .STEP_FRAMES(STEP), .SOLID_COLOR(SOLID)
    ) dut (
        .i_clk(clk),
        .i_resetn(rst_n),
        .bus(bus)
    );

    int ncmp = 0;
    int nfail = 0;

    // Reference state: frames started since reset, mode latched at last start,
    // previous y. Cursor position follows from the frame count alone.
    int starts = 0;
    int m_q = 0;
    int y_prev = 'hFFF;

    typedef struct {
        int          x;
        int          y;
        int          mode;
        logic [23:0] odd;
        logic [23:0] even;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_bar(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [47:0] ref_px(input int x, input int y, input int mode, input int fc);
        int cx, cy;
        logic [7:0] xb, xb1, yb, fb;
        cx = (fc / STEP) % H;
        cy = (fc / STEP) % V;
        if (x >= H || y >= V) return 48'h0;
        case (mode)
            0: begin
                if (x == 0)                               return {24'hFFFFFF, 24'h00FF00};
                if (x == cx)                              return {24'hFFFFFF, 24'hFFFFFF};
                if (x == H - 1)                           return {24'h00FF00, 24'hFFFFFF};
                if (y == 0 || y == cy || y == V - 1)      return {24'hFF0000, 24'hFF0000};
                return {24'h00FF00, 24'h00FF00};
            end
            1: return {ref_bar((x / 128) % 8), ref_bar((x / 128) % 8)};
            2: begin
                xb  = 8'(x % 256);
                xb1 = 8'((x + 1) % 256);
                yb  = 8'(y % 256);
                fb  = 8'(fc % 256);
                return {xb, yb, fb, xb1, yb, fb};
            end
            default: return {SOLID, SOLID};
        endcase
    endfunction

    // One pixel: drive at the falling edge, predict, clock, compare after the
    // following falling edge.
    task automatic cyc(input int x, input int y, input int m);
        logic [47:0] e;
        bit fs;
        bus.i_x    = 12'(x);
        bus.i_y    = 12'(y);
        bus.i_mode = 2'(m);
        e  = ref_px(x, y, m_q, starts);
        fs = (y == 0) && (y_prev != 0);
        if (fs) begin
            starts++;
            m_q = m;
        end
        y_prev = y;
        @(posedge clk);
        @(negedge clk);
        chk("color", {bus.o_color, bus.o_color_even}, e);
        chk("tick", 48'(bus.o_frame_tick), 48'(fs));
        chk("frame_cnt", 48'(bus.o_frame_cnt), 48'(starts % 65536));
    endtask

    task automatic model_reset();
        starts = 0;
        m_q    = 0;
        y_prev = 'hFFF;
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once.
    task automatic async_reset(input string nm);
        #2;
        rst_n = 1'b0;
        #1;
        chk({nm, "_color"}, {bus.o_color, bus.o_color_even}, 48'h0);
        chk({nm, "_tick"},  48'(bus.o_frame_tick), 48'h0);
        chk({nm, "_cnt"},   48'(bus.o_frame_cnt),  48'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_x = 12'd5; bus.i_y = 12'd5; bus.i_mode = 2'd0;
        vt[0] = '{x:5,    y:5,    mode:0, odd:24'h00FF00, even:24'h00FF00};
        vt[1] = '{x:0,    y:5,    mode:1, odd:24'hFFFFFF, even:24'h00FF00};
        vt[2] = '{x:959,  y:5,    mode:2, odd:24'h00FF00, even:24'hFFFFFF};
        vt[3] = '{x:5,    y:1199, mode:3, odd:24'hFF0000, even:24'hFF0000};
        vt[4] = '{x:960,  y:5,    mode:0, odd:24'h000000, even:24'h000000};
        vt[5] = '{x:5,    y:1200, mode:0, odd:24'h000000, even:24'h000000};
        vt[6] = '{x:4000, y:7,    mode:3, odd:24'h000000, even:24'h000000};

        #12;
        chk("rst_color", {bus.o_color, bus.o_color_even}, 48'h0);
        chk("rst_tick",  48'(bus.o_frame_tick), 48'h0);
        chk("rst_cnt",   48'(bus.o_frame_cnt),  48'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Before any frame start: mode stays 0 regardless of i_mode, no ticks.
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].x, vt[i].y, vt[i].mode);
            chk("vec", {bus.o_color, bus.o_color_even}, {vt[i].odd, vt[i].even});
            chk("vec_tick", 48'(bus.o_frame_tick), 48'h0);
        end

        // Seven frames in mode 2, then the gradient at x=255,y=3.
        for (int f = 0; f < 7; f++) begin
            cyc(10, 1, 2);
            cyc(10, 0, 2);
            chk("grad_tick", 48'(bus.o_frame_tick), 48'h1);
        end
        chk("cnt7", 48'(bus.o_frame_cnt), 48'd7);
        cyc(255, 3, 2);
        chk("grad", {bus.o_color, bus.o_color_even}, 48'hFF0307_000307);

        // Mode 1 latched; a mid-frame switch to mode 3 waits for the next start.
        cyc(10, 1, 1);
        cyc(10, 0, 1);
        cyc(0, 5, 3);
        chk("bar0", {bus.o_color, bus.o_color_even}, 48'hFFFFFF_FFFFFF);
        cyc(640, 5, 3);
        chk("bar5", {bus.o_color, bus.o_color_even}, 48'hFF0000_FF0000);
        cyc(640, 6, 3);
        chk("bar5_hold", {bus.o_color, bus.o_color_even}, 48'hFF0000_FF0000);
        cyc(640, 0, 3);
        chk("start_old_mode", {bus.o_color, bus.o_color_even}, 48'hFF0000_FF0000);
        cyc(640, 5, 3);
        chk("solid", {bus.o_color, bus.o_color_even}, 48'h0000FF_0000FF);

        // Tenth start in mode 0: cursor has advanced twice.
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(2, 5, 0);
        chk("cursor2", {bus.o_color, bus.o_color_even}, 48'hFFFFFF_FFFFFF);

        // y held at 0 yields a single tick.
        for (int i = 0; i < 20; i++) cyc(i * 7, 0, 0);
        chk("stuck_cnt", 48'(bus.o_frame_cnt), 48'd11);

        async_reset("midreset");
        cyc(3, 0, 0);
        chk("post_rst_tick", 48'(bus.o_frame_tick), 48'h1);
        chk("post_rst_cnt",  48'(bus.o_frame_cnt),  48'h1);

        // Randomized raster fragments against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int x, y, m;
            x = int'($urandom_range(0, 1000));
            y = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 1250));
            m = int'($urandom_range(0, 3));
            cyc(x, y, m);
        end

        // Cursor wrap: 4800 starts -> 1200 advances -> cur_x=240, cur_y=0.
        async_reset("wrapreset");
        for (int k = 0; k < 4800; k++) begin
            cyc((k % 2 == 0) ? 959 : int'($urandom_range(0, 959)), 1, 0);
            cyc(int'($urandom_range(0, 959)), 0, 0);
        end
        cyc(240, 7, 0);
        chk("wrap_curx", {bus.o_color, bus.o_color_even}, 48'hFFFFFF_FFFFFF);
        cyc(100, 1, 0);
        chk("wrap_cury", {bus.o_color, bus.o_color_even}, 48'h00FF00_00FF00);
        cyc(100, 1199, 0);
        chk("last_row", {bus.o_color, bus.o_color_even}, 48'hFF0000_FF0000);
        chk("wrap_cnt", 48'(bus.o_frame_cnt), 48'd4800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
